mem_stage_axi: RTL and testbench

MEM_STAGE_AXI -- requirements
Module: mem_stage_axi

---
 rtl/mem_stage_axi.sv | 278 +++++++++++++++++++++++++++
 tb/tb_mem_stage_axi.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_axi.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_axi
// Description : Pipeline memory stage. Accepts one op at a time, performs an
//               AXI-lite load or store (or passes the EX result through),
//               and presents the result with fault reporting downstream.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_axi #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32,
    parameter int CTX_W  = 70
) (
    input  logic                clk,
    input  logic                rst,
    // upstream
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ADDR_W-1:0]   in_addr,
    input  logic [XLEN-1:0]     in_wdata,
    input  logic [2:0]          in_funct3,
    input  logic                in_ren,
    input  logic                in_wen,
    input  logic [CTX_W-1:0]    in_ctx,
    // downstream
    output logic [CTX_W-1:0]    out_ctx,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_data,
    output logic                out_fault,
    output logic [1:0]          out_cause,
    // AXI-lite read
    output logic [ADDR_W-1:0]   araddr,
    output logic                arvalid,
    input  logic                arready,
    input  logic [XLEN-1:0]     rdata,
    input  logic [1:0]          rresp,
    input  logic                rvalid,
    output logic                rready,
    // AXI-lite write
    output logic [ADDR_W-1:0]   awaddr,
    output logic                awvalid,
    input  logic                awready,
    output logic [XLEN-1:0]     wdata,
    output logic [XLEN/8-1:0]   wstrb,
    output logic                wvalid,
    input  logic                wready,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready
);

    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_AR   = 3'd1;
    localparam logic [2:0] S_R    = 3'd2;
    localparam logic [2:0] S_AWW  = 3'd3;
    localparam logic [2:0] S_B    = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    localparam logic [1:0] CAUSE_NONE  = 2'b00;
    localparam logic [1:0] CAUSE_MISAL = 2'b01;
    localparam logic [1:0] CAUSE_BUS   = 2'b10;
    localparam logic [1:0] CAUSE_ILL   = 2'b11;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [CTX_W-1:0]  ctx_q, ctx_d;
    logic [XLEN-1:0]   data_q, data_d;
    logic              fault_q, fault_d;
    logic [1:0]        cause_q, cause_d;
    logic              aw_pend_q, aw_pend_d;
    logic              w_pend_q, w_pend_d;

    logic              w_accept;
    logic              w_illegal;
    logic              w_misal;
    logic [XLEN-1:0]   w_pass;
    logic [OFF_W-1:0]  w_off;
    logic [XLEN-1:0]   w_rsh;
    logic [XLEN-1:0]   w_load;
    logic [NB-1:0]     w_mask;

    // Non-memory ops forward the EX result zero-extended (or truncated) to XLEN
    if (ADDR_W >= XLEN) begin : g_pass_trunc
        assign w_pass = in_addr[XLEN-1:0];
    end else begin : g_pass_zext
        assign w_pass = {{(XLEN-ADDR_W){1'b0}}, in_addr};
    end

    assign w_accept  = in_valid & in_ready;
    assign in_ready  = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);

    assign out_valid = (state_q == S_DONE);
    assign out_data  = data_q;
    assign out_fault = fault_q;
    assign out_cause = cause_q;
    assign out_ctx   = ctx_q;

    assign w_off   = addr_q[OFF_W-1:0];
    assign araddr  = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign awaddr  = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign arvalid = (state_q == S_AR);
    assign rready  = (state_q == S_R);
    assign awvalid = (state_q == S_AWW) & aw_pend_q;
    assign wvalid  = (state_q == S_AWW) & w_pend_q;
    assign bready  = (state_q == S_B);
    assign wdata   = wdata_q << {w_off, 3'b000};
    assign wstrb   = w_mask << w_off;
    assign w_rsh   = rdata >> {w_off, 3'b000};

    // Classify the incoming op: illegal encodings take priority over alignment
    always_comb begin
        w_illegal = 1'b0;
        w_misal   = 1'b0;
        if (in_ren && in_wen) begin
            w_illegal = 1'b1;
        end else if (in_ren) begin
            if (in_funct3 == 3'b111) w_illegal = 1'b1;
            if ((XLEN == 32) && ((in_funct3 == 3'b011) || (in_funct3 == 3'b110)))
                w_illegal = 1'b1;
        end else if (in_wen) begin
            if (in_funct3[2]) w_illegal = 1'b1;
            if ((XLEN == 32) && (in_funct3 == 3'b011)) w_illegal = 1'b1;
        end
        if (in_ren || in_wen) begin
            case (in_funct3[1:0])
                2'b01:   w_misal = in_addr[0];
                2'b10:   w_misal = |in_addr[1:0];
                2'b11:   w_misal = |in_addr[2:0];
                default: w_misal = 1'b0;
            endcase
        end
    end

    // Extract and extend the addressed lane of the read beat
    always_comb begin
        case (funct3_q)
            3'b000:  w_load = XLEN'($signed(w_rsh[7:0]));
            3'b001:  w_load = XLEN'($signed(w_rsh[15:0]));
            3'b010:  w_load = XLEN'($signed(w_rsh[31:0]));
            3'b100:  w_load = XLEN'(w_rsh[7:0]);
            3'b101:  w_load = XLEN'(w_rsh[15:0]);
            3'b110:  w_load = XLEN'(w_rsh[31:0]);
            default: w_load = w_rsh;
        endcase
    end

    // Byte-enable pattern for the store size before lane shifting
    always_comb begin
        case (funct3_q[1:0])
            2'b00:   w_mask = NB'(1);
            2'b01:   w_mask = NB'(3);
            2'b10:   w_mask = NB'(15);
            default: w_mask = '1;
        endcase
    end

    // Next-state: bus sequencing, result capture, and op acceptance
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        funct3_d  = funct3_q;
        ctx_d     = ctx_q;
        data_d    = data_q;
        fault_d   = fault_q;
        cause_d   = cause_q;
        aw_pend_d = aw_pend_q;
        w_pend_d  = w_pend_q;

        case (state_q)
            S_AR: begin
                if (arready) state_d = S_R;
            end
            S_R: begin
                if (rvalid) begin
                    state_d = S_DONE;
                    if (rresp != 2'b00) begin
                        data_d  = '0;
                        fault_d = 1'b1;
                        cause_d = CAUSE_BUS;
                    end else begin
                        data_d  = w_load;
                        fault_d = 1'b0;
                        cause_d = CAUSE_NONE;
                    end
                end
            end
            S_AWW: begin
                // AW and W complete independently; leave once both are done
                if (awready) aw_pend_d = 1'b0;
                if (wready)  w_pend_d  = 1'b0;
                if ((!aw_pend_q || awready) && (!w_pend_q || wready))
                    state_d = S_B;
            end
            S_B: begin
                if (bvalid) begin
                    state_d = S_DONE;
                    data_d  = '0;
                    if (bresp != 2'b00) begin
                        fault_d = 1'b1;
                        cause_d = CAUSE_BUS;
                    end else begin
                        fault_d = 1'b0;
                        cause_d = CAUSE_NONE;
                    end
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: ;
        endcase

        // Acceptance overrides DONE retirement so back-to-back ops see no bubble
        if (w_accept) begin
            addr_d    = in_addr;
            wdata_d   = in_wdata;
            funct3_d  = in_funct3;
            ctx_d     = in_ctx;
            aw_pend_d = 1'b1;
            w_pend_d  = 1'b1;
            data_d    = '0;
            fault_d   = 1'b0;
            cause_d   = CAUSE_NONE;
            if (w_illegal) begin
                state_d = S_DONE;
                fault_d = 1'b1;
                cause_d = CAUSE_ILL;
            end else if (!in_ren && !in_wen) begin
                state_d = S_DONE;
                data_d  = w_pass;
            end else if (w_misal) begin
                state_d = S_DONE;
                fault_d = 1'b1;
                cause_d = CAUSE_MISAL;
            end else if (in_ren) begin
                state_d = S_AR;
            end else begin
                state_d = S_AWW;
            end
        end
    end

    // State and result registers; reset abandons any bus transaction in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            funct3_q  <= '0;
            ctx_q     <= '0;
            data_q    <= '0;
            fault_q   <= 1'b0;
            cause_q   <= CAUSE_NONE;
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            funct3_q  <= funct3_d;
            ctx_q     <= ctx_d;
            data_q    <= data_d;
            fault_q   <= fault_d;
            cause_q   <= cause_d;
            aw_pend_q <= aw_pend_d;
            w_pend_q  <= w_pend_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_axi.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage_axi
// Description : Directed self-checking bench for mem_stage_axi (XLEN=32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage_axi;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] in_addr, in_wdata;
    logic [2:0]  in_funct3;
    logic        in_ren, in_wen;
    logic [69:0] in_ctx, out_ctx;
    logic        out_valid, out_ready;
    logic [31:0] out_data;
    logic        out_fault;
    logic [1:0]  out_cause;
    logic [31:0] araddr;
    logic        arvalid, arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid, rready;
    logic [31:0] awaddr;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid, wready;
    logic [1:0]  bresp;
    logic        bvalid, bready;

    int n_checks = 0;
    int n_errors = 0;

    mem_stage_axi #(.XLEN(32), .ADDR_W(32), .CTX_W(70)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
        .in_wdata(in_wdata), .in_funct3(in_funct3), .in_ren(in_ren),
        .in_wen(in_wen), .in_ctx(in_ctx), .out_ctx(out_ctx),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_fault(out_fault), .out_cause(out_cause),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_op(input logic ren, input logic wen, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input logic [69:0] ctx);
        in_valid  = 1'b1;
        in_ren    = ren;
        in_wen    = wen;
        in_funct3 = f3;
        in_addr   = addr;
        in_wdata  = wd;
        in_ctx    = ctx;
    endtask

    task automatic retire();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("retired_valid", out_valid, 1'b0);
    endtask

    // Full load: AR held one cycle without arready, then R beat
    task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] rd, input logic [1:0] rr,
                            input logic [31:0] exp_data, input logic exp_fault,
                            input logic [1:0] exp_cause);
        @(negedge clk);
        drive_op(1'b1, 1'b0, f3, addr, 32'h0, 70'h5);
        check({tag, "_in_ready"}, in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_arvalid"}, arvalid, 1'b1);
        check({tag, "_araddr"}, araddr, {addr[31:2], 2'b00});
        @(negedge clk);
        check({tag, "_arvalid_hold"}, arvalid, 1'b1);
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        check({tag, "_arvalid_drop"}, arvalid, 1'b0);
        check({tag, "_rready"}, rready, 1'b1);
        rvalid = 1'b1; rdata = rd; rresp = rr;
        @(negedge clk);
        rvalid = 1'b0;
        check({tag, "_out_valid"}, out_valid, 1'b1);
        check({tag, "_out_data"}, out_data, exp_data);
        check({tag, "_fault"}, out_fault, exp_fault);
        check({tag, "_cause"}, out_cause, exp_cause);
        retire();
    endtask

    // Op that completes without bus activity: result one cycle after accept
    task automatic run_nobus(input string tag, input logic ren, input logic wen,
                             input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] exp_data, input logic exp_fault,
                             input logic [1:0] exp_cause);
        @(negedge clk);
        drive_op(ren, wen, f3, addr, 32'hDEAD_BEEF, 70'h3C);
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_arvalid"}, arvalid, 1'b0);
        check({tag, "_awvalid"}, awvalid, 1'b0);
        check({tag, "_out_valid"}, out_valid, 1'b1);
        check({tag, "_out_data"}, out_data, exp_data);
        check({tag, "_fault"}, out_fault, exp_fault);
        check({tag, "_cause"}, out_cause, exp_cause);
        check({tag, "_ctx"}, out_ctx, 70'h3C);
        retire();
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_addr = '0; in_wdata = '0; in_funct3 = '0;
        in_ren = 1'b0; in_wen = 1'b0; in_ctx = '0; out_ready = 1'b0;
        arready = 1'b0; rdata = '0; rresp = '0; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bresp = '0; bvalid = 1'b0;
        #2;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_arvalid", arvalid, 1'b0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_out_ctx", out_ctx, 70'h0);
        @(negedge clk);
        rst = 1'b0;

        // Loads with lane extraction and extension
        run_load("lb",  3'b000, 32'h8000_0003, 32'h80AB_CDEF, 2'b00, 32'hFFFF_FF80, 1'b0, 2'b00);
        run_load("lbu", 3'b100, 32'h8000_0003, 32'h80AB_CDEF, 2'b00, 32'h0000_0080, 1'b0, 2'b00);
        run_load("lh",  3'b001, 32'h8000_0002, 32'h80AB_CDEF, 2'b00, 32'hFFFF_80AB, 1'b0, 2'b00);
        run_load("lw",  3'b010, 32'h8000_0004, 32'h1234_5678, 2'b00, 32'h1234_5678, 1'b0, 2'b00);
        run_load("lerr", 3'b010, 32'h8000_0000, 32'h1234_5678, 2'b10, 32'h0, 1'b1, 2'b10);

        // Ops resolved at accept
        run_nobus("mis_lw", 1'b1, 1'b0, 3'b010, 32'h8000_0001, 32'h0, 1'b1, 2'b01);
        run_nobus("pass",   1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0000_1234, 1'b0, 2'b00);
        run_nobus("ill_rw", 1'b1, 1'b1, 3'b010, 32'h8000_0000, 32'h0, 1'b1, 2'b11);
        run_nobus("ill_ld", 1'b1, 1'b0, 3'b011, 32'h8000_0000, 32'h0, 1'b1, 2'b11);
        run_nobus("ill_sb4", 1'b0, 1'b1, 3'b100, 32'h8000_0000, 32'h0, 1'b1, 2'b11);

        // sh with AW accepted before W, and a delayed B
        @(negedge clk);
        drive_op(1'b0, 1'b1, 3'b001, 32'h8000_0002, 32'h0000_BEEF, 70'h7);
        @(negedge clk);
        in_valid = 1'b0;
        check("sh_awvalid", awvalid, 1'b1);
        check("sh_wvalid", wvalid, 1'b1);
        check("sh_awaddr", awaddr, 32'h8000_0000);
        check("sh_wdata", wdata, 32'hBEEF_0000);
        check("sh_wstrb", wstrb, 4'b1100);
        awready = 1'b1;
        @(negedge clk);
        awready = 1'b0;
        check("sh_aw_drop", awvalid, 1'b0);
        check("sh_w_hold", wvalid, 1'b1);
        check("sh_wdata_hold", wdata, 32'hBEEF_0000);
        wready = 1'b1;
        @(negedge clk);
        wready = 1'b0;
        check("sh_bready", bready, 1'b1);
        check("sh_no_early_valid", out_valid, 1'b0);
        @(negedge clk);
        check("sh_wait_b", out_valid, 1'b0);
        bvalid = 1'b1;
        @(negedge clk);
        bvalid = 1'b0;
        check("sh_out_valid", out_valid, 1'b1);
        check("sh_fault", out_fault, 1'b0);
        retire();

        // sw with both handshakes in one cycle, bus error on B
        @(negedge clk);
        drive_op(1'b0, 1'b1, 3'b010, 32'h8000_0004, 32'h1234_5678, 70'h8);
        @(negedge clk);
        in_valid = 1'b0;
        check("sw_wstrb", wstrb, 4'b1111);
        check("sw_wdata", wdata, 32'h1234_5678);
        awready = 1'b1; wready = 1'b1;
        @(negedge clk);
        awready = 1'b0; wready = 1'b0;
        check("sw_bready", bready, 1'b1);
        bvalid = 1'b1; bresp = 2'b10;
        @(negedge clk);
        bvalid = 1'b0; bresp = 2'b00;
        check("sw_fault", out_fault, 1'b1);
        check("sw_cause", out_cause, 2'b10);
        retire();

        // Stall in DONE for 3 cycles, then accept in the retire cycle
        @(negedge clk);
        drive_op(1'b0, 1'b0, 3'b000, 32'h0000_AAAA, 32'h0, 70'h11);
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("stall_valid", out_valid, 1'b1);
            check("stall_data", out_data, 32'h0000_AAAA);
            check("stall_ctx", out_ctx, 70'h11);
            check("stall_in_ready", in_ready, 1'b0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        drive_op(1'b0, 1'b0, 3'b000, 32'h0000_BBBB, 32'h0, 70'h22);
        #1;
        check("b2b_in_ready", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        check("b2b_valid", out_valid, 1'b1);
        check("b2b_data", out_data, 32'h0000_BBBB);
        check("b2b_ctx", out_ctx, 70'h22);
        retire();

        // Reset in R with rready high
        @(negedge clk);
        drive_op(1'b1, 1'b0, 3'b010, 32'h8000_0000, 32'h0, 70'h1);
        @(negedge clk);
        in_valid = 1'b0; arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        check("rstR_rready_pre", rready, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("rstR_rready", rready, 1'b0);
        check("rstR_out_valid", out_valid, 1'b0);
        check("rstR_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rstR_in_ready_after", in_ready, 1'b1);
        check("rstR_rready_after", rready, 1'b0);
        check("rstR_valid_after", out_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
